// File: rtl/sakebi_crc_stream_engine_if.sv
// Beat stream and CRC result handshake shared by the CRC engine and its producer/consumer.
// The master side drives input beats and takes results; the slave side is the engine.
interface sakebi_crc_stream_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 32
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [KEEP_WIDTH-1:0] i_keep;
    logic                  i_sof;
    logic                  i_last;
    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [CRC_WIDTH-1:0]  o_res_crc;
    logic                  o_res_match;

    modport master (
        output i_valid, i_data, i_keep, i_sof, i_last, i_res_ready,
        input  o_ready, o_res_valid, o_res_crc, o_res_match
    );

    modport slave (
        input  i_valid, i_data, i_keep, i_sof, i_last, i_res_ready,
        output o_ready, o_res_valid, o_res_crc, o_res_match
    );
endinterface

// File: rtl/sakebi_crc_stream_engine.sv
// Streaming parametrised CRC engine: folds every enabled byte of a beat in one cycle and
// holds the finished CRC plus residue-match flag on a valid/ready result port.
module sakebi_crc_stream_engine #(
    parameter int          DATA_WIDTH = 8,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
    parameter bit          REFLECT    = 1'b1,
    parameter logic [31:0] RESIDUE    = 32'h2144DF1C
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    sakebi_crc_stream_engine_if.slave    bus
);
    localparam logic [CRC_WIDTH-1:0] POLY_W    = POLY[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] INIT_W    = INIT[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] XOR_W     = XOR_OUT[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] RESIDUE_W = RESIDUE[CRC_WIDTH-1:0];

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    // Serial-equivalent shift of one byte; REFLECT feeds bit 0 first into the MSB-first register.
    function automatic logic [CRC_WIDTH-1:0] fold_byte(input logic [CRC_WIDTH-1:0] rem,
                                                       input logic [7:0]           b);
        logic [CRC_WIDTH-1:0] r;
        logic                 fb;
        r = rem;
        for (int i = 0; i < 8; i++) begin
            fb = r[CRC_WIDTH-1] ^ (REFLECT ? b[i] : b[7-i]);
            r  = {r[CRC_WIDTH-2:0], 1'b0};
            if (fb) r = r ^ POLY_W;
        end
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] fold_beat(input logic [CRC_WIDTH-1:0]  rem,
                                                       input logic [DATA_WIDTH-1:0] data,
                                                       input logic [KEEP_WIDTH-1:0] keep);
        logic [CRC_WIDTH-1:0] r;
        r = rem;
        for (int l = 0; l < KEEP_WIDTH; l++) begin
            if (keep[l]) r = fold_byte(r, data[8*l +: 8]);
        end
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] bitrev(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
        return r;
    endfunction

    state_t                state_p0;
    state_t                state_d;
    logic [CRC_WIDTH-1:0]  rem_p0;
    logic [CRC_WIDTH-1:0]  seed;
    logic [CRC_WIDTH-1:0]  rem_d;
    logic [CRC_WIDTH-1:0]  crc_out;
    logic [KEEP_WIDTH-1:0] keep_eff;
    logic                  accept;
    logic [CRC_WIDTH-1:0]  res_crc_p1;
    logic                  res_match_p1;

    always_comb begin
        accept   = bus.i_valid && (state_p0 != HOLD);
        keep_eff = bus.i_last ? bus.i_keep : {KEEP_WIDTH{1'b1}};
        // Any beat accepted from IDLE or flagged sof starts a fresh frame.
        seed     = ((state_p0 == IDLE) || bus.i_sof) ? INIT_W : rem_p0;
        rem_d    = fold_beat(seed, bus.i_data, keep_eff);
        crc_out  = (REFLECT ? bitrev(rem_d) : rem_d) ^ XOR_W;

        state_d = state_p0;
        unique case (state_p0)
            IDLE:  if (accept) state_d = bus.i_last ? HOLD : ACCUM;
            ACCUM: if (accept && bus.i_last) state_d = HOLD;
            HOLD:  if (bus.i_res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: running remainder and FSM; stage p1: latched result held through backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0     <= IDLE;
            rem_p0       <= INIT_W;
            res_crc_p1   <= '0;
            res_match_p1 <= 1'b0;
        end else begin
            state_p0 <= state_d;
            if (accept) rem_p0 <= rem_d;
            if (accept && bus.i_last) begin
                res_crc_p1   <= crc_out;
                res_match_p1 <= (crc_out == RESIDUE_W);
            end
        end
    end

    assign bus.o_ready     = i_rst_n && (state_p0 != HOLD);
    assign bus.o_res_valid = (state_p0 == HOLD);
    assign bus.o_res_crc   = res_crc_p1;
    assign bus.o_res_match = res_match_p1;
endmodule

// File: tb/tb_sakebi_crc_stream_engine.sv
// Directed bench for the CRC stream engine: 8-bit and 32-bit instances of the standard CRC-32.
module tb_sakebi_crc_stream_engine;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    sakebi_crc_stream_engine_if #(.DATA_WIDTH(8),  .CRC_WIDTH(32)) b8 ();
    sakebi_crc_stream_engine_if #(.DATA_WIDTH(32), .CRC_WIDTH(32)) b32 ();

    sakebi_crc_stream_engine #(.DATA_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b8.slave)
    );
    sakebi_crc_stream_engine #(.DATA_WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b32.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- 8-bit instance helpers ----------------
    task automatic beat8(input logic [7:0] d, input logic sof, input logic last);
        int n;
        @(negedge clk);
        b8.i_valid = 1'b1; b8.i_data = d; b8.i_sof = sof; b8.i_last = last; b8.i_keep = 1'b1;
        n = 0;
        while (b8.o_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n == 40) chk("beat8_ready", b8.o_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle8();
        @(negedge clk);
        b8.i_valid = 1'b0; b8.i_sof = 1'b0; b8.i_last = 1'b0;
    endtask

    task automatic frame_123(input logic last);
        for (int i = 0; i < 9; i++) beat8(8'h31 + 8'(i), i == 0, last && (i == 8));
    endtask

    task automatic res8(input string tag, input logic [31:0] crc, input logic m,
                        input logic do_crc, input logic do_m);
        int n;
        @(negedge clk);
        n = 0;
        while (b8.o_res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, b8.o_res_valid, 1);
        if (do_crc) chk({tag, "_crc"}, b8.o_res_crc, crc);
        if (do_m) chk({tag, "_match"}, b8.o_res_match, m);
        b8.i_res_ready = 1'b1;
        @(negedge clk);
        b8.i_res_ready = 1'b0;
        chk({tag, "_ready_back"}, b8.o_ready, 1);
        chk({tag, "_valid_clr"}, b8.o_res_valid, 0);
    endtask

    // ---------------- 32-bit instance helpers ----------------
    task automatic beat32(input logic [31:0] d, input logic [3:0] keep,
                          input logic sof, input logic last);
        int n;
        @(negedge clk);
        b32.i_valid = 1'b1; b32.i_data = d; b32.i_keep = keep; b32.i_sof = sof; b32.i_last = last;
        n = 0;
        while (b32.o_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n == 40) chk("beat32_ready", b32.o_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle32();
        @(negedge clk);
        b32.i_valid = 1'b0; b32.i_sof = 1'b0; b32.i_last = 1'b0;
    endtask

    task automatic res32(input string tag, input logic [31:0] crc, input logic m,
                         input logic do_crc, input logic do_m);
        int n;
        @(negedge clk);
        n = 0;
        while (b32.o_res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, b32.o_res_valid, 1);
        if (do_crc) chk({tag, "_crc"}, b32.o_res_crc, crc);
        if (do_m) chk({tag, "_match"}, b32.o_res_match, m);
        b32.i_res_ready = 1'b1;
        @(negedge clk);
        b32.i_res_ready = 1'b0;
        chk({tag, "_ready_back"}, b32.o_ready, 1);
        chk({tag, "_valid_clr"}, b32.o_res_valid, 0);
    endtask

    initial begin
        b8.i_valid = 0; b8.i_data = 0; b8.i_keep = 0; b8.i_sof = 0; b8.i_last = 0; b8.i_res_ready = 0;
        b32.i_valid = 0; b32.i_data = 0; b32.i_keep = 0; b32.i_sof = 0; b32.i_last = 0;
        b32.i_res_ready = 0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", b8.o_ready, 0);
        chk("rst_valid", b8.o_res_valid, 0);
        chk("rst_crc", b8.o_res_crc, 32'h0);
        chk("rst_match", b8.o_res_match, 0);
        chk("rst_ready32", b32.o_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", b8.o_ready, 1);
        chk("rel_ready32", b32.o_ready, 1);

        // "123456789" byte-wide; result visible right after the last accept
        frame_123(1'b1);
        idle8();
        chk("t1_latency", b8.o_res_valid, 1);
        res8("t1", 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        // RX check with appended FCS
        frame_123(1'b0);
        beat8(8'h26, 1'b0, 1'b0);
        beat8(8'h39, 1'b0, 1'b0);
        beat8(8'hF4, 1'b0, 1'b0);
        beat8(8'hCB, 1'b0, 1'b1);
        idle8();
        res8("rx", 32'h2144DF1C, 1'b1, 1'b1, 1'b1);

        // Corrupted first byte (0x31 -> 0x30) with the same FCS
        beat8(8'h30, 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) beat8(8'h31 + 8'(i), 1'b0, 1'b0);
        beat8(8'h26, 1'b0, 1'b0);
        beat8(8'h39, 1'b0, 1'b0);
        beat8(8'hF4, 1'b0, 1'b0);
        beat8(8'hCB, 1'b0, 1'b1);
        idle8();
        res8("rxflip", 32'h0, 1'b0, 1'b0, 1'b1);

        // Restart: abandoned 3-byte frame, then single 0x00 with sof+last
        beat8(8'h31, 1'b1, 1'b0);
        beat8(8'h32, 1'b0, 1'b0);
        beat8(8'h33, 1'b0, 1'b0);
        beat8(8'h00, 1'b1, 1'b1);
        idle8();
        res8("restart", 32'hD202EF8D, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("restart_single", b8.o_res_valid, 0);

        // Backpressure with a second frame pending
        frame_123(1'b1);
        @(negedge clk);
        b8.i_valid = 1'b1; b8.i_data = 8'h00; b8.i_sof = 1'b1; b8.i_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", b8.o_res_valid, 1);
            chk("bp_stable", b8.o_res_crc, 32'hCBF43926);
            chk("bp_ready", b8.o_ready, 0);
            @(negedge clk);
        end
        res8("bp1", 32'hCBF43926, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        idle8();
        res8("bp2", 32'hD202EF8D, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame
        beat8(8'h31, 1'b1, 1'b0);
        beat8(8'h32, 1'b0, 1'b0);
        beat8(8'h33, 1'b0, 1'b0);
        #2;
        b8.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", b8.o_ready, 0);
        chk("rstmid_valid", b8.o_res_valid, 0);
        chk("rstmid_crc", b8.o_res_crc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in HOLD
        frame_123(1'b1);
        idle8();
        chk("hold_valid", b8.o_res_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rsthold_valid", b8.o_res_valid, 0);
        chk("rsthold_crc", b8.o_res_crc, 32'h0);
        chk("rsthold_match", b8.o_res_match, 0);
        chk("rsthold_ready", b8.o_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_123(1'b1);
        idle8();
        res8("after_rst", 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        // 32-bit beats; keep ignored on non-last beats, upper lanes of last beat junk
        beat32(32'h34333231, 4'hF, 1'b1, 1'b0);
        beat32(32'h38373635, 4'h0, 1'b0, 1'b0);
        beat32(32'hFFFFFF39, 4'b0001, 1'b0, 1'b1);
        idle32();
        res32("w32", 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        // Same frame with valid gaps
        beat32(32'h34333231, 4'hF, 1'b1, 1'b0);
        idle32();
        idle32();
        beat32(32'h38373635, 4'hF, 1'b0, 1'b0);
        idle32();
        beat32(32'h00000039, 4'b0001, 1'b0, 1'b1);
        idle32();
        res32("w32gap", 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        // RX check on the wide instance
        beat32(32'h34333231, 4'hF, 1'b1, 1'b0);
        beat32(32'h38373635, 4'hF, 1'b0, 1'b0);
        beat32(32'hF4392639, 4'hF, 1'b0, 1'b0);
        beat32(32'h000000CB, 4'b0001, 1'b0, 1'b1);
        idle32();
        res32("rx32", 32'h2144DF1C, 1'b1, 1'b1, 1'b1);

        // Last beat with keep=0: empty frame, CRC of nothing is 0
        beat32(32'h12345678, 4'h0, 1'b1, 1'b1);
        idle32();
        res32("empty", 32'h0, 1'b0, 1'b1, 1'b1);

        // Non-contiguous keep must still produce a result and release
        beat32(32'hA5A5A5A5, 4'b0101, 1'b1, 1'b1);
        idle32();
        res32("noncontig", 32'h0, 1'b0, 1'b0, 1'b0);
        beat32(32'h34333231, 4'hF, 1'b1, 1'b0);
        beat32(32'h38373635, 4'hF, 1'b0, 1'b0);
        beat32(32'h00000039, 4'b0001, 1'b0, 1'b1);
        idle32();
        res32("recover", 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
